// File: rtl/memory_map_io_pkg.sv
// memory_map_pkg: shared address-map helpers and the region encoding
// for the memory_map_io CPU data-memory map.
//
// Optional feature macro: MMIO_IRQ_EN (adds the IRQ_MASK register at io_base-1).
//
// Contents:
//   region_t       - decoded region of a CPU address
//   io_base()      - first address of the IO window (oports, iports, STATUS)
//   oport_addr()   - address of output port k
//   iport_addr()   - address of input port j
//   status_addr()  - address of the STATUS register (top of the map)
//   irqmask_addr() - address of IRQ_MASK, just below the IO window
package memory_map_pkg;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_OPORT,
    REG_IPORT,
    REG_STATUS,
    REG_IRQMASK
  } region_t;

  function automatic int io_base(input int aw, input int n_oport, input int n_iport);
    return (1 << aw) - (n_oport + n_iport + 1);
  endfunction

  function automatic int oport_addr(input int aw, input int n_oport, input int n_iport,
                                    input int k);
    return io_base(aw, n_oport, n_iport) + k;
  endfunction

  function automatic int iport_addr(input int aw, input int n_oport, input int n_iport,
                                    input int j);
    return io_base(aw, n_oport, n_iport) + n_oport + j;
  endfunction

  function automatic int status_addr(input int aw);
    return (1 << aw) - 1;
  endfunction

  function automatic int irqmask_addr(input int aw, input int n_oport, input int n_iport);
    return io_base(aw, n_oport, n_iport) - 1;
  endfunction

endpackage

// File: rtl/dualport_ram.sv
// dualport_ram: true dual-port RAM, 2^AW words of DW bits, one clock per port.
// Both ports read synchronously (1-cycle latency, old data on read-during-write).
// Contents are not reset.
//
// Ports:
//   clk_a, we_a, addr_a, wd_a, rd_a  - port A (CPU side)
//   clk_b, we_b, addr_b, wd_b, rd_b  - port B (monitor side)
//
// Each port owns its own bank so that no storage element is written from two
// clock domains. A word is the XOR of both banks; a port writes
// (new_data ^ other_bank) into its own bank so the XOR yields new_data.
// Same-address writes from both ports in the same instant leave the word undefined.
module dualport_ram #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wd_a,
  output logic [DW-1:0] rd_a,
  input  logic          clk_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wd_b,
  output logic [DW-1:0] rd_b
);

  logic [DW-1:0] bank_a [0:(1<<AW)-1];
  logic [DW-1:0] bank_b [0:(1<<AW)-1];

  // Port A: write into bank A, read the XOR of both banks (old data on collision).
  always_ff @(posedge clk_a) begin
    if (we_a) begin
      bank_a[addr_a] <= wd_a ^ bank_b[addr_a];
    end
    rd_a <= bank_a[addr_a] ^ bank_b[addr_a];
  end

  // Port B: mirror of port A on the monitor clock.
  always_ff @(posedge clk_b) begin
    if (we_b) begin
      bank_b[addr_b] <= wd_b ^ bank_a[addr_b];
    end
    rd_b <= bank_a[addr_b] ^ bank_b[addr_b];
  end

endmodule

// File: rtl/memory_map_io_iport_sync.sv
// iport_sync: two-flop synchroniser for one DW-wide asynchronous input port,
// plus a third register holding the previous synchronised value so that a
// change can be detected.
//
// Ports:
//   clock, reset - CPU clock, async active-high reset (clears all stages)
//   din          - asynchronous input port value
//   value        - synchronised value (second stage)
//   change       - high while the synchronised value differs from the previous one
module iport_sync #(
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] value,
  output logic          change
);

  logic [DW-1:0] s1;
  logic [DW-1:0] s2;
  logic [DW-1:0] prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign value  = s2;
  assign change = (s2 != prev);

endmodule

// File: rtl/memory_map_io.sv
// memory_map_io: CPU data-memory map combining a dual-port RAM, N_OPORT output
// port registers, N_IPORT synchronised input ports with sticky change flags and
// a write-1-to-clear STATUS register at the top address.
//
// Optional feature macro: MMIO_IRQ_EN
//   defined   - IRQ_MASK register at IO_BASE-1 (taken from RAM), registered irq
//   undefined - that address stays RAM, irq tied to 0
//
// Ports:
//   clock, reset          - CPU clock, async active-high reset (CPU-side logic only)
//   we, MA, WD            - CPU write enable, address, write data
//   RD                    - CPU read data, 1 cycle after the address
//   prg_clock             - monitor clock
//   prg_we, prg_MA, prg_WD - monitor write enable/address/data (RAM only)
//   prg_RD                - monitor read data, 1-cycle latency, never reset
//   oport                 - output ports, port k at [k*DW +: DW]
//   iport                 - asynchronous input ports, same packing
//   irq                   - change interrupt
module memory_map_io
  import memory_map_pkg::*;
#(
  parameter int            DW        = 8,
  parameter int            AW        = 8,
  parameter int            N_OPORT   = 1,
  parameter int            N_IPORT   = 1,
  parameter logic [DW-1:0] OPORT_RST = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [AW-1:0]         MA,
  input  logic [DW-1:0]         WD,
  output logic [DW-1:0]         RD,
  input  logic                  prg_clock,
  input  logic                  prg_we,
  input  logic [AW-1:0]         prg_MA,
  input  logic [DW-1:0]         prg_WD,
  output logic [DW-1:0]         prg_RD,
  output logic [N_OPORT*DW-1:0] oport,
  input  logic [N_IPORT*DW-1:0] iport,
  output logic                  irq
);

  localparam logic [AW-1:0] OPORT_BASE_A = AW'(oport_addr(AW, N_OPORT, N_IPORT, 0));
  localparam logic [AW-1:0] IPORT_BASE_A = AW'(iport_addr(AW, N_OPORT, N_IPORT, 0));
  localparam logic [AW-1:0] STATUS_A     = AW'(status_addr(AW));
`ifdef MMIO_IRQ_EN
  localparam logic [AW-1:0] IRQMASK_A    = AW'(irqmask_addr(AW, N_OPORT, N_IPORT));
`endif

  region_t       region;
  logic [AW-1:0] offset;
  region_t       region_q;
  logic [AW-1:0] offset_q;
  logic          rd_valid_q;

  logic [DW-1:0] ram_rd;
  logic          ram_we;

  logic [DW-1:0] oport_reg [N_OPORT];
  logic [DW-1:0] iport_val [N_IPORT];
  logic [N_IPORT-1:0] iport_chg;

  logic [1:0]         prime;
  logic               primed;
  logic [N_IPORT-1:0] flags;
  logic [N_IPORT-1:0] status_clr;

  logic [DW-1:0] rd_mux;

  // Address decode. STATUS sits at the very top, iports just below it, oports
  // below those; everything lower is RAM (minus IRQ_MASK when enabled).
  // offset is the port index within the oport or iport group.
  always_comb begin
    region = REG_RAM;
    offset = '0;
    if (MA == STATUS_A) begin
      region = REG_STATUS;
    end else if (MA >= IPORT_BASE_A) begin
      region = REG_IPORT;
      offset = MA - IPORT_BASE_A;
    end else if (MA >= OPORT_BASE_A) begin
      region = REG_OPORT;
      offset = MA - OPORT_BASE_A;
    end
`ifdef MMIO_IRQ_EN
    else if (MA == IRQMASK_A) begin
      region = REG_IRQMASK;
    end
`endif
  end

  assign ram_we = we && (region == REG_RAM);

  dualport_ram #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .clk_a (clock),
    .we_a  (ram_we),
    .addr_a(MA),
    .wd_a  (WD),
    .rd_a  (ram_rd),
    .clk_b (prg_clock),
    .we_b  (prg_we),
    .addr_b(prg_MA),
    .wd_b  (prg_WD),
    .rd_b  (prg_RD)
  );

  // The read select is registered alongside the RAM read so that every region
  // answers with the same 1-cycle latency. rd_valid_q forces RD to 0 while
  // reset is held, since the RAM output register itself is not reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      region_q   <= REG_RAM;
      offset_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      region_q   <= region;
      offset_q   <= offset;
      rd_valid_q <= 1'b1;
    end
  end

  // Output port registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_OPORT; k++) begin
        oport_reg[k] <= OPORT_RST;
      end
    end else if (we && (region == REG_OPORT)) begin
      for (int k = 0; k < N_OPORT; k++) begin
        if (offset == AW'(k)) begin
          oport_reg[k] <= WD;
        end
      end
    end
  end

  for (genvar k = 0; k < N_OPORT; k++) begin : g_oport
    assign oport[k*DW +: DW] = oport_reg[k];
  end

  for (genvar j = 0; j < N_IPORT; j++) begin : g_iport
    iport_sync #(
      .DW(DW)
    ) u_sync (
      .clock (clock),
      .reset (reset),
      .din   (iport[j*DW +: DW]),
      .value (iport_val[j]),
      .change(iport_chg[j])
    );
  end

  // Priming: the synchroniser pipeline fills with the input value present at
  // reset release; that first 0 -> value step must not raise a flag, so change
  // detection waits until the counter saturates at 3.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prime <= 2'd0;
    end else if (!primed) begin
      prime <= prime + 2'd1;
    end
  end

  assign primed = (prime == 2'd3);

  assign status_clr = (we && (region == REG_STATUS)) ? WD[N_IPORT-1:0] : '0;

  // Sticky change flags. The set term is OR-ed in after the clear so that a
  // change arriving in the same cycle as a W1C is not lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flags <= '0;
    end else begin
      flags <= (flags & ~status_clr) | (primed ? iport_chg : '0);
    end
  end

`ifdef MMIO_IRQ_EN
  logic [DW-1:0] irq_mask;

  // Interrupt mask and registered interrupt request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (we && (region == REG_IRQMASK)) begin
        irq_mask <= WD;
      end
      irq <= |(flags & irq_mask[N_IPORT-1:0]);
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Read mux driven by the registered select. Register-backed regions show
  // their current value, so a write followed by a read in the next cycle
  // returns the new contents.
  always_comb begin
    rd_mux = '0;
    if (rd_valid_q) begin
      case (region_q)
        REG_RAM: rd_mux = ram_rd;
        REG_OPORT: begin
          for (int k = 0; k < N_OPORT; k++) begin
            if (offset_q == AW'(k)) begin
              rd_mux = oport_reg[k];
            end
          end
        end
        REG_IPORT: begin
          for (int j = 0; j < N_IPORT; j++) begin
            if (offset_q == AW'(j)) begin
              rd_mux = iport_val[j];
            end
          end
        end
        REG_STATUS: rd_mux = DW'(flags);
`ifdef MMIO_IRQ_EN
        REG_IRQMASK: rd_mux = irq_mask;
`endif
        default: rd_mux = '0;
      endcase
    end
  end

  assign RD = rd_mux;

endmodule

// File: tb/tb_memory_map_io.sv
// tb_memory_map_io: directed self-checking bench for memory_map_io with default
// parameters (RAM 0x00-0xFC, oport0 0xFD, iport0 0xFE, STATUS 0xFF).
// With MMIO_IRQ_EN defined, IRQ_MASK at 0xFC is exercised as well.
module tb_memory_map_io;

  logic       clock;
  logic       reset;
  logic       we;
  logic [7:0] MA;
  logic [7:0] WD;
  logic [7:0] RD;
  logic       prg_clock;
  logic       prg_we;
  logic [7:0] prg_MA;
  logic [7:0] prg_WD;
  logic [7:0] prg_RD;
  logic [7:0] oport;
  logic [7:0] iport;
  logic       irq;

  int checks = 0;
  int errors = 0;

  memory_map_io dut (
    .clock    (clock),
    .reset    (reset),
    .we       (we),
    .MA       (MA),
    .WD       (WD),
    .RD       (RD),
    .prg_clock(prg_clock),
    .prg_we   (prg_we),
    .prg_MA   (prg_MA),
    .prg_WD   (prg_WD),
    .prg_RD   (prg_RD),
    .oport    (oport),
    .iport    (iport),
    .irq      (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial prg_clock = 1'b0;
  always #7 prg_clock = ~prg_clock;

  // Drive one CPU bus cycle: inputs are set 1 time unit after an edge, captured
  // on the next rising edge, and outputs are sampled 1 unit after that edge.
  task automatic applyStimulus(input logic w, input logic [7:0] a, input logic [7:0] d);
    we = w;
    MA = a;
    WD = d;
    @(posedge clock);
    #1;
    we = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic prgCycle();
    @(posedge prg_clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset  = 1'b0;
    we     = 1'b0;
    MA     = 8'h00;
    WD     = 8'h00;
    prg_we = 1'b0;
    prg_MA = 8'h00;
    prg_WD = 8'h00;
    iport  = 8'h55;
    #1 reset = 1'b1;
    #2;
    checkOutput("reset_oport", {24'h0, oport}, 32'h00);
    checkOutput("reset_rd", {24'h0, RD}, 32'h00);
    checkOutput("reset_irq", {31'h0, irq}, 32'h0);

    @(posedge clock);
    #1 reset = 1'b0;

    // Input value present at reset release must not raise a flag.
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 8'h00);
    applyStimulus(1'b0, 8'hFF, 8'h00);
    checkOutput("prime_status", {24'h0, RD}, 32'h00);
    applyStimulus(1'b0, 8'hFE, 8'h00);
    checkOutput("prime_iport", {24'h0, RD}, 32'h55);

    // RAM write/read and read-during-write on port A.
    applyStimulus(1'b1, 8'h10, 8'hA5);
    applyStimulus(1'b0, 8'h10, 8'h00);
    checkOutput("ram_read", {24'h0, RD}, 32'hA5);
    applyStimulus(1'b1, 8'h20, 8'h11);
    applyStimulus(1'b1, 8'h20, 8'h22);
    checkOutput("ram_rdw_old", {24'h0, RD}, 32'h11);
    applyStimulus(1'b0, 8'h20, 8'h00);
    checkOutput("ram_rdw_new", {24'h0, RD}, 32'h22);

    // Monitor port reads what the CPU wrote, and owns RAM[0xFD].
    prg_MA = 8'h10;
    prgCycle();
    checkOutput("prg_read", {24'h0, prg_RD}, 32'hA5);
    prg_we = 1'b1;
    prg_MA = 8'hFD;
    prg_WD = 8'h77;
    prgCycle();
    prg_we = 1'b0;
    prgCycle();
    checkOutput("prg_write_fd", {24'h0, prg_RD}, 32'h77);

    // Output port write goes to the register, not to RAM.
    applyStimulus(1'b1, 8'hFD, 8'h3C);
    checkOutput("oport_write", {24'h0, oport}, 32'h3C);
    applyStimulus(1'b0, 8'hFD, 8'h00);
    checkOutput("oport_read", {24'h0, RD}, 32'h3C);
    prgCycle();
    checkOutput("prg_fd_unchanged", {24'h0, prg_RD}, 32'h77);

    // Input change: flag sets on the third edge.
    iport = 8'h56;
    applyStimulus(1'b0, 8'hFF, 8'h00);
    applyStimulus(1'b0, 8'hFF, 8'h00);
    checkOutput("flag_edge2", {24'h0, RD}, 32'h00);
    applyStimulus(1'b0, 8'hFF, 8'h00);
    checkOutput("flag_edge3", {24'h0, RD}, 32'h01);
    applyStimulus(1'b0, 8'hFE, 8'h00);
    checkOutput("iport_new", {24'h0, RD}, 32'h56);

    // W1C: writing 0 keeps the flag, writing 1 clears it.
    applyStimulus(1'b1, 8'hFF, 8'h00);
    applyStimulus(1'b0, 8'hFF, 8'h00);
    checkOutput("w1c_zero", {24'h0, RD}, 32'h01);
    applyStimulus(1'b1, 8'hFF, 8'h01);
    applyStimulus(1'b0, 8'hFF, 8'h00);
    checkOutput("w1c_one", {24'h0, RD}, 32'h00);

    // Set wins over a simultaneous clear.
    iport = 8'h57;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'hFF, 8'h00);
    checkOutput("flag_again", {24'h0, RD}, 32'h01);
    iport = 8'h58;
    applyStimulus(1'b0, 8'hFF, 8'h00);
    applyStimulus(1'b0, 8'hFF, 8'h00);
    applyStimulus(1'b1, 8'hFF, 8'h01);
    applyStimulus(1'b0, 8'hFF, 8'h00);
    checkOutput("set_beats_clear", {24'h0, RD}, 32'h01);
    applyStimulus(1'b1, 8'hFF, 8'h01);
    applyStimulus(1'b0, 8'hFF, 8'h00);
    checkOutput("clear_after", {24'h0, RD}, 32'h00);

    // Writes to the iport address are ignored.
    applyStimulus(1'b1, 8'hFE, 8'hAA);
    applyStimulus(1'b0, 8'hFE, 8'h00);
    checkOutput("iport_write_ignored", {24'h0, RD}, 32'h58);
    checkOutput("oport_kept", {24'h0, oport}, 32'h3C);

`ifdef MMIO_IRQ_EN
    applyStimulus(1'b1, 8'hFC, 8'h01);
    applyStimulus(1'b0, 8'hFC, 8'h00);
    checkOutput("irqmask_read", {24'h0, RD}, 32'h01);
    iport = 8'h59;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'hFF, 8'h00);
    checkOutput("irq_flag_set", {24'h0, RD}, 32'h01);
    checkOutput("irq_not_yet", {31'h0, irq}, 32'h0);
    applyStimulus(1'b0, 8'hFF, 8'h00);
    checkOutput("irq_asserted", {31'h0, irq}, 32'h1);
    applyStimulus(1'b1, 8'hFF, 8'h01);
    checkOutput("irq_w1c_edge", {31'h0, irq}, 32'h1);
    applyStimulus(1'b0, 8'hFF, 8'h00);
    checkOutput("irq_cleared", {31'h0, irq}, 32'h0);
    applyStimulus(1'b1, 8'hFC, 8'h00);
    iport = 8'h5A;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'hFF, 8'h00);
    checkOutput("irq_masked_flag", {24'h0, RD}, 32'h01);
    checkOutput("irq_masked", {31'h0, irq}, 32'h0);
    applyStimulus(1'b1, 8'hFF, 8'h01);
`else
    // Without the interrupt option 0xFC is plain RAM and irq never rises.
    applyStimulus(1'b1, 8'hFC, 8'h99);
    applyStimulus(1'b0, 8'hFC, 8'h00);
    checkOutput("ram_fc", {24'h0, RD}, 32'h99);
    checkOutput("irq_tied", {31'h0, irq}, 32'h0);
`endif

    // Reset in the middle of an oport write discards the write.
    applyStimulus(1'b0, 8'hFD, 8'h00);
    checkOutput("pre_reset_rd", {24'h0, RD}, 32'h3C);
    we = 1'b1;
    MA = 8'hFD;
    WD = 8'hEE;
    reset = 1'b1;
    #2;
    checkOutput("midrun_reset_oport", {24'h0, oport}, 32'h00);
    checkOutput("midrun_reset_rd", {24'h0, RD}, 32'h00);
    @(posedge clock);
    #1;
    we = 1'b0;
    reset = 1'b0;
    checkOutput("reset_write_discarded", {24'h0, oport}, 32'h00);
    prgCycle();
    checkOutput("prg_rd_after_reset", {24'h0, prg_RD}, 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
